// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: requester ports m0/m1,
// the shared slave-side request/response and the registered grant vector.
interface mem_bus_arbiter_if #(
  parameter int AW = 32
);
  logic [AW-1:0] m0_address;
  logic          m0_read;
  logic          m0_write;
  logic [31:0]   m0_writedata;
  logic [3:0]    m0_byteenable;
  logic [31:0]   m0_readdata;
  logic          m0_waitrequest;

  logic [AW-1:0] m1_address;
  logic          m1_read;
  logic          m1_write;
  logic [31:0]   m1_writedata;
  logic [3:0]    m1_byteenable;
  logic [31:0]   m1_readdata;
  logic          m1_waitrequest;

  logic [AW-1:0] s_address;
  logic          s_read;
  logic          s_write;
  logic [31:0]   s_writedata;
  logic [3:0]    s_byteenable;
  logic [31:0]   s_readdata;
  logic          s_waitrequest;

  logic [1:0]    grant;

  modport arbiter (
    input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    output m0_readdata, m0_waitrequest,
    input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    output m1_readdata, m1_waitrequest,
    output s_address, s_read, s_write, s_writedata, s_byteenable,
    input  s_readdata, s_waitrequest,
    output grant
  );

  // Requester side: drives both m0/m1 request groups and observes the grant.
  modport master (
    output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
    input  m0_readdata, m0_waitrequest,
    output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    input  m1_readdata, m1_waitrequest,
    input  grant
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
    output s_readdata, s_waitrequest
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory-bus arbiter: one grant per transfer, round-robin or
// fixed priority, combinational forwarding of the owner onto the shared bus.
module mem_bus_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.arbiter bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic          r_lsp;
  logic          w_lsp_next;
  logic [1:0]    r_grant;
  logic          w_req0;
  logic          w_req1;
  logic          w_sel0;
  logic          w_sel1;
  logic [AW-1:0] w_s_address;

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;

  always_comb begin
    w_state_next = r_state;
    w_lsp_next   = r_lsp;
    case (r_state)
      ST_IDLE: begin
        // On a tie, round-robin hands the bus to whoever was not served last.
        if (w_req0 && w_req1) begin
          w_state_next = (RR_EN && !r_lsp) ? ST_GRANT1 : ST_GRANT0;
        end else if (w_req0) begin
          w_state_next = ST_GRANT0;
        end else if (w_req1) begin
          w_state_next = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!w_req0) begin
          w_state_next = ST_IDLE;
        end else if (!bus.s_waitrequest) begin
          w_state_next = ST_IDLE;
          w_lsp_next   = 1'b0;
        end
      end
      ST_GRANT1: begin
        if (!w_req1) begin
          w_state_next = ST_IDLE;
        end else if (!bus.s_waitrequest) begin
          w_state_next = ST_IDLE;
          w_lsp_next   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lsp   <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_lsp   <= w_lsp_next;
      r_grant <= {w_state_next == ST_GRANT1, w_state_next == ST_GRANT0};
    end
  end

  // Reset masks the forwarding path so an in-flight transfer drops in the reset cycle.
  assign w_sel0 = (r_state == ST_GRANT0) && !reset;
  assign w_sel1 = (r_state == ST_GRANT1) && !reset;

  assign w_s_address = w_sel0 ? bus.m0_address :
                       w_sel1 ? bus.m1_address : '0;

  assign bus.s_address    = w_s_address;
  assign bus.s_write      = (w_sel0 & bus.m0_write) | (w_sel1 & bus.m1_write);
  assign bus.s_read       = (w_sel0 & bus.m0_read & ~bus.m0_write) |
                            (w_sel1 & bus.m1_read & ~bus.m1_write);
  assign bus.s_writedata  = w_sel0 ? bus.m0_writedata :
                            w_sel1 ? bus.m1_writedata : 32'h0;
  assign bus.s_byteenable = w_sel0 ? bus.m0_byteenable :
                            w_sel1 ? bus.m1_byteenable : 4'h0;

  assign bus.m0_waitrequest = w_sel0 ? bus.s_waitrequest : 1'b1;
  assign bus.m1_waitrequest = w_sel1 ? bus.s_waitrequest : 1'b1;
  assign bus.m0_readdata    = w_sel0 ? bus.s_readdata : 32'h0;
  assign bus.m1_readdata    = w_sel1 ? bus.s_readdata : 32'h0;

  assign bus.grant = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a directed cycle table plus random traffic checked
// against an owner/last-served model, run on round-robin and fixed-priority copies.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam logic [31:0] RDV = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW)) bus_rr ();
  mem_bus_arbiter_if #(.AW(AW)) bus_fp ();

  mem_bus_arbiter #(.RR_EN(1'b1), .AW(AW)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  mem_bus_arbiter #(.RR_EN(1'b0), .AW(AW)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp));

  int total = 0;
  int bad   = 0;

  logic        cur_rst, cur_m0r, cur_m0w, cur_m1r, cur_m1w, cur_sw;
  logic [31:0] cur_a0, cur_a1, cur_wd0, cur_wd1, cur_srd;
  logic [3:0]  cur_be0, cur_be1;

  int own_rr, lsp_rr, own_fp, lsp_fp;

  typedef struct packed {
    logic [5:0] in;    // {rst, m0_read, m0_write, m1_read, m1_write, s_waitrequest}
    logic [1:0] g_rr;
    logic [1:0] g_fp;
    logic [3:0] fl;    // round-robin copy: {m0_wait, m1_wait, s_read, s_write}
    logic [1:0] rd_on; // round-robin copy: {m0 sees s_readdata, m1 sees s_readdata}
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t v(input logic [5:0] in, input logic [1:0] grr, input logic [1:0] gfp,
                             input logic [3:0] fl, input logic [1:0] rd);
    vec_t r;
    r.in = in; r.g_rr = grr; r.g_fp = gfp; r.fl = fl; r.rd_on = rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [3:0] be0, input logic [3:0] be1, input logic [31:0] srd);
    {cur_rst, cur_m0r, cur_m0w, cur_m1r, cur_m1w, cur_sw} = in;
    cur_a0 = a0; cur_a1 = a1; cur_wd0 = wd0; cur_wd1 = wd1;
    cur_be0 = be0; cur_be1 = be1; cur_srd = srd;
    reset = cur_rst;
    bus_rr.m0_read = cur_m0r; bus_rr.m0_write = cur_m0w; bus_rr.m1_read = cur_m1r; bus_rr.m1_write = cur_m1w;
    bus_fp.m0_read = cur_m0r; bus_fp.m0_write = cur_m0w; bus_fp.m1_read = cur_m1r; bus_fp.m1_write = cur_m1w;
    bus_rr.m0_address = a0; bus_rr.m1_address = a1; bus_fp.m0_address = a0; bus_fp.m1_address = a1;
    bus_rr.m0_writedata = wd0; bus_rr.m1_writedata = wd1; bus_fp.m0_writedata = wd0; bus_fp.m1_writedata = wd1;
    bus_rr.m0_byteenable = be0; bus_rr.m1_byteenable = be1; bus_fp.m0_byteenable = be0; bus_fp.m1_byteenable = be1;
    bus_rr.s_waitrequest = cur_sw; bus_fp.s_waitrequest = cur_sw;
    bus_rr.s_readdata = srd; bus_fp.s_readdata = srd;
  endtask

  // Expected bus view given who currently owns the bus (-1 = nobody).
  task automatic check_dut(input string tag, input int own, input logic [1:0] g,
                           input logic sr, input logic sw, input logic [31:0] sa,
                           input logic [31:0] swd, input logic [3:0] sbe,
                           input logic m0wt, input logic m1wt,
                           input logic [31:0] m0rd, input logic [31:0] m1rd);
    logic [1:0]  eg;
    logic        esr, esw, e0w, e1w;
    logic [31:0] esa, ewd, e0rd, e1rd;
    logic [3:0]  ebe;
    eg  = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    esr = 1'b0; esw = 1'b0; esa = '0; ewd = '0; ebe = '0;
    e0w = 1'b1; e1w = 1'b1; e0rd = '0; e1rd = '0;
    if (!cur_rst && own == 0) begin
      esa = cur_a0; ewd = cur_wd0; ebe = cur_be0;
      esw = cur_m0w; esr = cur_m0r && !cur_m0w;
      e0w = cur_sw; e0rd = cur_srd;
    end else if (!cur_rst && own == 1) begin
      esa = cur_a1; ewd = cur_wd1; ebe = cur_be1;
      esw = cur_m1w; esr = cur_m1r && !cur_m1w;
      e1w = cur_sw; e1rd = cur_srd;
    end
    chk({tag, "_grant"}, 128'(g), 128'(eg));
    chk({tag, "_strobe_wait"}, 128'({sr, sw, m0wt, m1wt}), 128'({esr, esw, e0w, e1w}));
    chk({tag, "_bus"}, 128'({sa, swd, sbe}), 128'({esa, ewd, ebe}));
    chk({tag, "_readdata"}, 128'({m0rd, m1rd}), 128'({e0rd, e1rd}));
  endtask

  task automatic model_check();
    check_dut("rr", own_rr, bus_rr.grant, bus_rr.s_read, bus_rr.s_write, bus_rr.s_address,
              bus_rr.s_writedata, bus_rr.s_byteenable, bus_rr.m0_waitrequest,
              bus_rr.m1_waitrequest, bus_rr.m0_readdata, bus_rr.m1_readdata);
    check_dut("fp", own_fp, bus_fp.grant, bus_fp.s_read, bus_fp.s_write, bus_fp.s_address,
              bus_fp.s_writedata, bus_fp.s_byteenable, bus_fp.m0_waitrequest,
              bus_fp.m1_waitrequest, bus_fp.m0_readdata, bus_fp.m1_readdata);
  endtask

  // One grant per transfer; ties go to the non-last-served requester (rr) or m0.
  task automatic model_step(input bit rr, inout int own, inout int lsp);
    bit q0, q1, qn;
    q0 = cur_m0r | cur_m0w;
    q1 = cur_m1r | cur_m1w;
    if (cur_rst) begin
      own = -1; lsp = 1;
    end else if (own < 0) begin
      if (q0 && q1) own = rr ? 1 - lsp : 0;
      else if (q0)  own = 0;
      else if (q1)  own = 1;
    end else begin
      qn = (own == 0) ? q0 : q1;
      if (!qn) own = -1;
      else if (!cur_sw) begin lsp = own; own = -1; end
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step(1'b1, own_rr, lsp_rr);
    model_step(1'b0, own_fp, lsp_fp);
    #1;
  endtask

  initial begin
    tbl[0]  = v(6'b100000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[1]  = v(6'b010000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[2]  = v(6'b010000, 2'b01, 2'b01, 4'b0110, 2'b10);
    tbl[3]  = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[4]  = v(6'b100000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[5]  = v(6'b010100, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[6]  = v(6'b010100, 2'b01, 2'b01, 4'b0110, 2'b10);
    tbl[7]  = v(6'b010100, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[8]  = v(6'b010100, 2'b10, 2'b01, 4'b1010, 2'b01);
    tbl[9]  = v(6'b010100, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[10] = v(6'b010100, 2'b01, 2'b01, 4'b0110, 2'b10);
    tbl[11] = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[12] = v(6'b000011, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[13] = v(6'b000011, 2'b10, 2'b10, 4'b1101, 2'b01);
    tbl[14] = v(6'b000011, 2'b10, 2'b10, 4'b1101, 2'b01);
    tbl[15] = v(6'b000011, 2'b10, 2'b10, 4'b1101, 2'b01);
    tbl[16] = v(6'b000010, 2'b10, 2'b10, 4'b1001, 2'b01);
    tbl[17] = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[18] = v(6'b000011, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[19] = v(6'b000011, 2'b10, 2'b10, 4'b1101, 2'b01);
    tbl[20] = v(6'b100011, 2'b10, 2'b10, 4'b1100, 2'b00);
    tbl[21] = v(6'b010100, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[22] = v(6'b010100, 2'b01, 2'b01, 4'b0110, 2'b10);
    tbl[23] = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[24] = v(6'b011000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[25] = v(6'b011000, 2'b01, 2'b01, 4'b0101, 2'b10);
    tbl[26] = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[27] = v(6'b000101, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[28] = v(6'b000001, 2'b10, 2'b10, 4'b1100, 2'b01);
    tbl[29] = v(6'b010100, 2'b00, 2'b00, 4'b1100, 2'b00);
    tbl[30] = v(6'b010100, 2'b10, 2'b01, 4'b1010, 2'b01);
    tbl[31] = v(6'b000000, 2'b00, 2'b00, 4'b1100, 2'b00);

    drive(6'b100000, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    own_rr = -1; lsp_rr = 1; own_fp = -1; lsp_fp = 1;

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].in, 32'h0000_0040, 32'h0000_0080, 32'h1111_1111, 32'hDEAD_BEEF,
            4'hF, 4'h3, RDV);
      @(negedge clk);
      $display("vec %0d in=%b grant_rr=%b grant_fp=%b", i, tbl[i].in, bus_rr.grant, bus_fp.grant);
      chk($sformatf("vec%0d_grant_rr", i), 128'(bus_rr.grant), 128'(tbl[i].g_rr));
      chk($sformatf("vec%0d_grant_fp", i), 128'(bus_fp.grant), 128'(tbl[i].g_fp));
      chk($sformatf("vec%0d_flags", i),
          128'({bus_rr.m0_waitrequest, bus_rr.m1_waitrequest, bus_rr.s_read, bus_rr.s_write}),
          128'(tbl[i].fl));
      chk($sformatf("vec%0d_readdata", i), 128'({bus_rr.m0_readdata, bus_rr.m1_readdata}),
          128'({tbl[i].rd_on[1] ? RDV : 32'h0, tbl[i].rd_on[0] ? RDV : 32'h0}));
      model_check();
      finish_cycle();
    end

    for (int n = 0; n < 2000; n++) begin
      logic [5:0] in;
      in[5] = ($urandom_range(0, 49) == 0);
      in[4] = ($urandom_range(0, 2) != 0);
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 2) != 0);
      in[1] = ($urandom_range(0, 3) == 0);
      in[0] = ($urandom_range(0, 2) == 0);
      drive(in, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom), $urandom);
      @(negedge clk);
      if (n % 100 == 0)
        $display("rand %0d in=%b grant_rr=%b grant_fp=%b", n, in, bus_rr.grant, bus_fp.grant);
      model_check();
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 SHALL have parameter AW, default 32: address width of all address ports.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 m0_address / m1_address  in  AW  requester byte address.
REQ-007 m0_read / m1_read  in  1  read request.
REQ-008 m0_write / m1_write  in  1  write request.
REQ-009 m0_writedata / m1_writedata  in  32  store data.
REQ-010 m0_byteenable / m1_byteenable  in  4  byte lanes.
REQ-011 m0_readdata / m1_readdata  out  32  load data returned to the requester.
REQ-012 m0_waitrequest / m1_waitrequest  out  1  stall to the requester.
REQ-013 s_address, s_read, s_write, s_writedata, s_byteenable  out  AW/1/1/32/4  shared memory-bus request.
REQ-014 s_readdata  in  32; s_waitrequest  in  1  shared memory-bus response.
REQ-015 grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT0, GRANT1, plus a 1-bit last-served pointer lsp.
REQ-017 Request definition: reqN = mN_read | mN_write.
REQ-018 IDLE, no request: SHALL stay in IDLE.
REQ-019 IDLE, single request: SHALL enter GRANT of that requester on the next edge; arbitration latency is exactly 1 cycle.
REQ-020 IDLE, both requesting, RR_EN=1: SHALL grant the requester not equal to lsp.
REQ-021 IDLE, both requesting, RR_EN=0: SHALL grant m0.
REQ-022 In GRANTn: s_* request outputs SHALL combinationally follow mn_*.
REQ-023 In GRANTn: mn_waitrequest SHALL equal s_waitrequest, and mn_readdata SHALL equal s_readdata.
REQ-024 In IDLE: s_read = s_write = 0, s_address = 0, s_writedata = 0, s_byteenable = 0.
REQ-025 A requester not granted SHALL see waitrequest = 1 and readdata = 0.
REQ-026 Completion: a cycle in GRANTn with reqn=1 and s_waitrequest=0 SHALL be one completed transfer.
REQ-027 On completion: FSM SHALL return to IDLE, lsp SHALL be set to n, and one grant covers exactly one transfer.
REQ-028 Back-to-back requests from one requester SHALL incur one IDLE cycle between transfers.
REQ-029 reqn deasserted while in GRANTn (abandoned request): SHALL return to IDLE next edge, leave lsp unchanged, drive no slave strobe that cycle.
REQ-030 mn_read and mn_write both 1: s_write SHALL be forwarded and s_read forced 0.
REQ-031 A requester that raises a request in the completion cycle of the other SHALL be eligible in the following IDLE cycle.
REQ-032 Under RR_EN=1, no requester SHALL wait more than one foreign transfer while continuously requesting.
REQ-033 grant SHALL be a registered decode of state, never 11.

Reset
REQ-034 reset=1 SHALL force IDLE, lsp=1 (m0 wins first tie), grant=00, all s_* strobes 0, both m*_waitrequest=1, both m*_readdata=0.
REQ-035 reset asserted mid-transfer SHALL abort immediately: strobes low in the reset cycle, no completion counted, lsp=1.
REQ-036 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-037 Scenario: m0 read 0x0000_0040, s_waitrequest low -> grant=01 one cycle after request; m0_waitrequest=0 in that cycle; m0_readdata=s_readdata; then IDLE.
REQ-038 Scenario: both request continuously, RR_EN=1, out of reset -> grant sequence 01,00,10,00,01,... with strict alternation.
REQ-039 Scenario: same stimulus, RR_EN=0 -> m0 granted every transfer; m1_waitrequest stays 1.
REQ-040 Scenario: m1 write 0xDEADBEEF, byteenable 0011, s_waitrequest high 3 cycles -> s_write, s_writedata, s_byteenable held stable 4 cycles; m0 stalled throughout.
REQ-041 Scenario: reset pulsed in second waitrequest cycle of an m1 transfer -> next cycle grant=00, s_write=0; a subsequent tie is granted to m0.
REQ-042 Scenario: m0 read and write both asserted -> s_write=1, s_read=0.
